// File: rtl/binarization_pkg.sv
// Shared definitions for the adaptive-binarization sequencer: controller states,
// default geometry and the watchdog counter sizing rule.
package binarization_pkg;

    localparam int WIDTH_DEF    = 256;
    localparam int HEIGHT_DEF   = 256;
    localparam int ADDR_W_DEF   = 16;
    localparam int THR_W_DEF    = 8;
    localparam int WD_SLACK_DEF = 16;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_INT_KICK = 3'd1,
        S_INT_RUN  = 3'd2,
        S_BIN_KICK = 3'd3,
        S_BIN_RUN  = 3'd4,
        S_READY    = 3'd5,
        S_ERR      = 3'd6
    } state_t;

    // One spare bit keeps the preload value clear of the counter's top bit.
    function automatic int wd_width(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage

// File: rtl/bin_rd_arbiter.sv
// Two-way round-robin arbiter sharing the single result read port between the
// display scanner and the dump reader; address is registered, data valid one cycle later.
module bin_rd_arbiter
    import binarization_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              bin_clk,
    input  logic              rst_n,
    input  logic              grant_en,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    input  logic              dump_req,
    input  logic [ADDR_W-1:0] dump_addr,
    input  logic              bin_data,
    output logic              disp_gnt,
    output logic              dump_gnt,
    output logic              disp_vld,
    output logic              dump_vld,
    output logic              rd_data,
    output logic [ADDR_W-1:0] pixel_address
);

    logic rr_dump;

    assign disp_gnt = grant_en && disp_req && (!dump_req || !rr_dump);
    assign dump_gnt = grant_en && dump_req && (!disp_req || rr_dump);

    // bin_data follows the registered address, so it is the bit of the granted read.
    assign rd_data = (disp_vld || dump_vld) && bin_data;

    // Address is forced back to zero whenever reads are not allowed.
    always_ff @(posedge bin_clk) begin
        if (!rst_n) begin
            rr_dump       <= 1'b0;
            disp_vld      <= 1'b0;
            dump_vld      <= 1'b0;
            pixel_address <= '0;
        end else begin
            disp_vld <= disp_gnt;
            dump_vld <= dump_gnt;
            if (disp_gnt) begin
                pixel_address <= disp_addr;
                rr_dump       <= 1'b1;
            end else if (dump_gnt) begin
                pixel_address <= dump_addr;
                rr_dump       <= 1'b0;
            end else if (!grant_en) begin
                pixel_address <= '0;
            end
        end
    end

endmodule

// File: rtl/binarization_sequencer.sv
// Top-level controller: latches the window half-size, runs the integral and threshold
// passes under a watchdog, then opens the result port to the readers.
module binarization_sequencer
    import binarization_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int HEIGHT   = HEIGHT_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int THR_W    = THR_W_DEF,
    parameter int WD_SLACK = WD_SLACK_DEF
) (
    input  logic              bin_clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [THR_W-1:0]  thr_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              int_ctrl,
    output logic              bin_ctrl,
    output logic [THR_W-1:0]  thres_length,
    input  logic              int_busy,
    input  logic              bin_busy,
    output logic [ADDR_W-1:0] pixel_address,
    input  logic              bin_data,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    input  logic              dump_req,
    input  logic [ADDR_W-1:0] dump_addr,
    output logic              disp_gnt,
    output logic              dump_gnt,
    output logic              disp_vld,
    output logic              dump_vld,
    output logic              rd_data
);

    localparam int              WD_W    = wd_width(WIDTH * HEIGHT + WD_SLACK);
    localparam logic [WD_W-1:0] WD_INIT = WD_W'(WIDTH * HEIGHT + WD_SLACK);

    state_t            state, state_next;
    logic [WD_W-1:0]   wd;
    logic [2:0]        kick_age;
    logic              busy_seen;
    logic              bad_thr_q;
    logic              done_q;
    logic              ready_flag;
    logic              run_busy;
    logic              start_ok_state;
    logic              thr_ok;
    logic              accept;

    assign start_ok_state = start && (state == S_IDLE || state == S_READY);
    assign thr_ok         = (thr_in != '0) && (32'(thr_in) < WIDTH / 2);
    assign accept         = start_ok_state && thr_ok;
    assign run_busy       = (state == S_BIN_RUN) ? bin_busy : int_busy;

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        int_ctrl   = 1'b0;
        bin_ctrl   = 1'b0;
        err        = bad_thr_q;
        done       = done_q;
        case (state)
            S_IDLE, S_READY: begin
                if (accept) state_next = S_INT_KICK;
            end
            S_INT_KICK: begin
                busy       = 1'b1;
                int_ctrl   = 1'b1;
                state_next = S_INT_RUN;
            end
            S_BIN_KICK: begin
                busy       = 1'b1;
                bin_ctrl   = 1'b1;
                state_next = S_BIN_RUN;
            end
            S_INT_RUN, S_BIN_RUN: begin
                busy = 1'b1;
                // A pass ends on the falling edge of its busy flag; a flag that
                // never rose shortly after the kick is treated like a hang.
                if (busy_seen && !run_busy)
                    state_next = (state == S_INT_RUN) ? S_BIN_KICK : S_READY;
                else if (wd == '0 || (!busy_seen && !run_busy && kick_age == 3'd3))
                    state_next = S_ERR;
            end
            S_ERR: begin
                err        = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge bin_clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            thres_length <= '0;
            wd           <= '0;
            kick_age     <= '0;
            busy_seen    <= 1'b0;
            bad_thr_q    <= 1'b0;
            done_q       <= 1'b0;
            ready_flag   <= 1'b0;
        end else begin
            state      <= state_next;
            bad_thr_q  <= start_ok_state && !thr_ok;
            done_q     <= (state == S_BIN_RUN) && (state_next == S_READY);
            ready_flag <= (state_next == S_READY);
            if (accept) thres_length <= thr_in;
            case (state)
                S_INT_KICK, S_BIN_KICK: begin
                    wd        <= WD_INIT;
                    kick_age  <= '0;
                    busy_seen <= 1'b0;
                end
                S_INT_RUN, S_BIN_RUN: begin
                    if (wd != '0) wd <= wd - WD_W'(1);
                    if (kick_age != 3'd7) kick_age <= kick_age + 3'd1;
                    if (run_busy) busy_seen <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A start request in the same cycle always takes priority over a read.
    bin_rd_arbiter #(
        .ADDR_W(ADDR_W)
    ) u_arb (
        .bin_clk      (bin_clk),
        .rst_n        (rst_n),
        .grant_en     (ready_flag && !start),
        .disp_req     (disp_req),
        .disp_addr    (disp_addr),
        .dump_req     (dump_req),
        .dump_addr    (dump_addr),
        .bin_data     (bin_data),
        .disp_gnt     (disp_gnt),
        .dump_gnt     (dump_gnt),
        .disp_vld     (disp_vld),
        .dump_vld     (dump_vld),
        .rd_data      (rd_data),
        .pixel_address(pixel_address)
    );

endmodule

// File: tb/tb_binarization_sequencer.sv
// Self-checking bench for binarization_sequencer on a reduced 32x8 image, with a
// behavioural datapath model and a round-robin read reference.
module tb_binarization_sequencer;

    localparam int WIDTH    = 32;
    localparam int HEIGHT   = 8;
    localparam int ADDR_W   = 8;
    localparam int THR_W    = 8;
    localparam int WD_SLACK = 16;
    localparam int PASS_LEN = WIDTH * HEIGHT;
    localparam int WD_CYC   = WIDTH * HEIGHT + WD_SLACK;

    logic              bin_clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [THR_W-1:0]  thr_in;
    logic              busy, done, err, int_ctrl, bin_ctrl;
    logic [THR_W-1:0]  thres_length;
    logic              int_busy, bin_busy;
    logic [ADDR_W-1:0] pixel_address;
    logic              bin_data;
    logic              disp_req, dump_req;
    logic [ADDR_W-1:0] disp_addr, dump_addr;
    logic              disp_gnt, dump_gnt, disp_vld, dump_vld, rd_data;

    int   total = 0;
    int   bad   = 0;
    bit   int_stuck = 1'b0;
    bit   favor_disp = 1'b1;
    logic [THR_W-1:0] last_thr = '0;

    typedef struct {
        logic [7:0] thr;
        logic       exp_err;
    } vec_t;

    vec_t vecs[7];

    binarization_sequencer #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W), .THR_W(THR_W), .WD_SLACK(WD_SLACK)
    ) dut (
        .bin_clk(bin_clk), .rst_n(rst_n), .start(start), .thr_in(thr_in),
        .busy(busy), .done(done), .err(err), .int_ctrl(int_ctrl), .bin_ctrl(bin_ctrl),
        .thres_length(thres_length), .int_busy(int_busy), .bin_busy(bin_busy),
        .pixel_address(pixel_address), .bin_data(bin_data),
        .disp_req(disp_req), .disp_addr(disp_addr), .dump_req(dump_req), .dump_addr(dump_addr),
        .disp_gnt(disp_gnt), .dump_gnt(dump_gnt), .disp_vld(disp_vld), .dump_vld(dump_vld),
        .rd_data(rd_data)
    );

    always #5 bin_clk = ~bin_clk;

    // Result memory model: an arbitrary fixed bit pattern over the address space.
    function automatic logic ref_bit(input logic [ADDR_W-1:0] a);
        return a[0] ^ a[2] ^ a[7] ^ (a[5] & a[1]);
    endfunction

    assign bin_data = ref_bit(pixel_address);

    // Integral datapath: busy for one image's worth of cycles per kick, or stuck on request.
    initial begin
        int_busy = 1'b0;
        forever begin
            @(negedge bin_clk);
            if (int_ctrl === 1'b1) begin
                int_busy = 1'b1;
                repeat (PASS_LEN) @(negedge bin_clk);
                while (int_stuck) @(negedge bin_clk);
                int_busy = 1'b0;
            end
        end
    end

    initial begin
        bin_busy = 1'b0;
        forever begin
            @(negedge bin_clk);
            if (bin_ctrl === 1'b1) begin
                bin_busy = 1'b1;
                repeat (PASS_LEN) @(negedge bin_clk);
                bin_busy = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] thr);
        @(negedge bin_clk);
        start  = 1'b1;
        thr_in = thr;
        @(negedge bin_clk);
        start  = 1'b0;
        thr_in = 8'($urandom);
    endtask

    task automatic startPass(input logic [7:0] thr, input logic exp_err);
        applyStimulus(thr);
        checkOutput("err_after_start", 32'(err), 32'(exp_err));
        checkOutput("int_ctrl_after_start", 32'(int_ctrl), 32'(!exp_err));
        checkOutput("busy_after_start", 32'(busy), 32'(!exp_err));
        if (!exp_err) last_thr = thr;
        checkOutput("thres_length", 32'(thres_length), 32'(last_thr));
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_pulses"}, {29'd0, done, err, int_ctrl | bin_ctrl}, 0);
        checkOutput({tag, "_thres_length"}, 32'(thres_length), 0);
        checkOutput({tag, "_pixel_address"}, 32'(pixel_address), 0);
        checkOutput({tag, "_rd_port"}, {27'd0, disp_gnt, dump_gnt, disp_vld, dump_vld, rd_data}, 0);
    endtask

    // Runs until the done pulse; while the passes run no read may be granted.
    task automatic waitDone();
        int cycles = 0;
        int bin_pulses = 0;
        bit got_done = 1'b0;
        bit got_err = 1'b0;
        while (!got_done && cycles < 2000) begin
            @(negedge bin_clk);
            cycles++;
            if (done) got_done = 1'b1;
            else begin
                checkOutput("gnt_in_pass", {30'd0, disp_gnt, dump_gnt}, 0);
                checkOutput("addr_in_pass", 32'(pixel_address), 0);
            end
            if (bin_ctrl) bin_pulses++;
            if (err) got_err = 1'b1;
        end
        checkOutput("done_seen", 32'(got_done), 1);
        checkOutput("bin_ctrl_pulses", 32'(bin_pulses), 1);
        checkOutput("err_in_pass", 32'(got_err), 0);
        checkOutput("busy_at_done", 32'(busy), 0);
    endtask

    // Readers hold each request until granted; fixed mode keeps both requesting every cycle.
    task automatic runReads(input int n, input bit fixed_mode);
        bit pd = 1'b0, pm = 1'b0, gd, gm;
        bit exp_dv = 1'b0, exp_mv = 1'b0;
        logic exp_data = 1'b0;
        logic [ADDR_W-1:0] ad = '0, am = '0;
        for (int c = 0; c <= n; c++) begin
            @(negedge bin_clk);
            checkOutput("disp_vld", 32'(disp_vld), 32'(exp_dv));
            checkOutput("dump_vld", 32'(dump_vld), 32'(exp_mv));
            if (exp_dv || exp_mv) checkOutput("rd_data", 32'(rd_data), 32'(exp_data));
            if (c == n) begin
                pd = 1'b0;
                pm = 1'b0;
            end else if (fixed_mode) begin
                pd = 1'b1; ad = 8'h10;
                pm = 1'b1; am = 8'h20;
            end else begin
                if (!pd && $urandom_range(0, 99) < 60) begin pd = 1'b1; ad = 8'($urandom); end
                if (!pm && $urandom_range(0, 99) < 60) begin pm = 1'b1; am = 8'($urandom); end
            end
            disp_req = pd; disp_addr = ad;
            dump_req = pm; dump_addr = am;
            #1;
            gd = pd && (!pm || favor_disp);
            gm = pm && !gd;
            checkOutput("disp_gnt", 32'(disp_gnt), 32'(gd));
            checkOutput("dump_gnt", 32'(dump_gnt), 32'(gm));
            if (gd) begin pd = 1'b0; favor_disp = 1'b0; exp_data = ref_bit(ad); end
            if (gm) begin pm = 1'b0; favor_disp = 1'b1; exp_data = ref_bit(am); end
            exp_dv = gd;
            exp_mv = gm;
        end
        disp_req = 1'b0;
        dump_req = 1'b0;
    endtask

    initial begin
        int cnt;
        bit got;
        int binp;

        vecs[0] = '{thr: 8'd9,   exp_err: 1'b0};
        vecs[1] = '{thr: 8'd0,   exp_err: 1'b1};
        vecs[2] = '{thr: 8'd128, exp_err: 1'b1};
        vecs[3] = '{thr: 8'd16,  exp_err: 1'b1};
        vecs[4] = '{thr: 8'd15,  exp_err: 1'b0};
        vecs[5] = '{thr: 8'd255, exp_err: 1'b1};
        vecs[6] = '{thr: 8'd1,   exp_err: 1'b0};

        rst_n = 1'b0; start = 1'b0; thr_in = '0;
        disp_req = 1'b0; dump_req = 1'b0; disp_addr = '0; dump_addr = '0;
        repeat (2) @(negedge bin_clk);
        checkResetOutputs("reset");
        rst_n = 1'b1;

        $display("[TB] start acceptance table");
        foreach (vecs[i]) begin
            startPass(vecs[i].thr, vecs[i].exp_err);
            if (vecs[i].exp_err) begin
                @(negedge bin_clk);
                checkOutput("err_pulse_end", {29'd0, err, int_ctrl, busy}, 0);
            end else begin
                waitDone();
                checkOutput("thres_after_done", 32'(thres_length), 32'(last_thr));
            end
        end

        $display("[TB] alternating reads with both readers requesting");
        runReads(6, 1'b1);
        $display("[TB] random reads");
        runReads(200, 1'b0);

        $display("[TB] start wins over a read, earlier grant still delivers");
        @(negedge bin_clk);
        dump_req = 1'b1; dump_addr = 8'hA7;
        #1;
        checkOutput("sw_dump_gnt", {30'd0, disp_gnt, dump_gnt}, 1);
        favor_disp = 1'b1;
        @(negedge bin_clk);
        checkOutput("sw_dump_vld", 32'(dump_vld), 1);
        checkOutput("sw_rd_data", 32'(rd_data), 32'(ref_bit(8'hA7)));
        dump_req = 1'b0;
        disp_req = 1'b1; disp_addr = 8'h5C;
        start = 1'b1; thr_in = 8'd4;
        #1;
        checkOutput("sw_no_gnt_on_start", {30'd0, disp_gnt, dump_gnt}, 0);
        @(negedge bin_clk);
        start = 1'b0; disp_req = 1'b0;
        last_thr = 8'd4;
        checkOutput("sw_int_ctrl", 32'(int_ctrl), 1);
        checkOutput("sw_thres", 32'(thres_length), 4);
        checkOutput("sw_disp_vld", 32'(disp_vld), 0);
        checkOutput("sw_addr_cleared", 32'(pixel_address), 0);
        waitDone();

        $display("[TB] read held through a whole run");
        startPass(8'd3, 1'b0);
        disp_req = 1'b1; disp_addr = 8'h33;
        waitDone();
        checkOutput("held_gnt_at_ready", {30'd0, disp_gnt, dump_gnt}, 2);
        favor_disp = 1'b0;
        @(negedge bin_clk);
        disp_req = 1'b0;
        checkOutput("held_vld", 32'(disp_vld), 1);
        checkOutput("held_rd_data", 32'(rd_data), 32'(ref_bit(8'h33)));
        checkOutput("held_addr", 32'(pixel_address), 32'h33);

        $display("[TB] watchdog on stuck integral pass");
        int_stuck = 1'b1;
        startPass(8'd7, 1'b0);
        cnt = 0; got = 1'b0; binp = 0;
        while (!got && cnt < 400) begin
            @(negedge bin_clk);
            cnt++;
            if (bin_ctrl) binp++;
            if (err) got = 1'b1;
        end
        checkOutput("wd_err_seen", 32'(got), 1);
        checkOutput("wd_err_window", 32'(cnt >= WD_CYC && cnt <= WD_CYC + 6), 1);
        checkOutput("wd_no_bin_ctrl", 32'(binp), 0);
        checkOutput("wd_busy", 32'(busy), 0);
        @(negedge bin_clk);
        checkOutput("wd_after", {29'd0, err, busy, done}, 0);
        int_stuck = 1'b0;

        $display("[TB] reset in the middle of the threshold pass");
        cnt = 0;
        while (int_busy && cnt < 20) begin @(negedge bin_clk); cnt++; end
        startPass(8'd9, 1'b0);
        cnt = 0;
        while (!bin_ctrl && cnt < 1000) begin @(negedge bin_clk); cnt++; end
        checkOutput("mid_bin_ctrl_seen", 32'(bin_ctrl), 1);
        repeat (40) @(negedge bin_clk);
        rst_n = 1'b0;
        @(negedge bin_clk);
        rst_n = 1'b1;
        favor_disp = 1'b1;
        last_thr = '0;
        checkResetOutputs("midrst");
        repeat (5) begin
            @(negedge bin_clk);
            checkOutput("midrst_quiet", {28'd0, busy, done, err, int_ctrl | bin_ctrl}, 0);
        end
        cnt = 0;
        while (bin_busy && cnt < 400) begin @(negedge bin_clk); cnt++; end
        checkOutput("midrst_dp_released", 32'(bin_busy), 0);
        startPass(8'd12, 1'b0);
        waitDone();
        runReads(3, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
